// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler and engine: state encoding,
// line-config field widths and encodings, and the shadow config payload.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DIV_W   = 32;
    localparam int unsigned FIELD_W = 2;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    localparam logic [FIELD_W-1:0] DATA_5    = 2'd0;
    localparam logic [FIELD_W-1:0] DATA_6    = 2'd1;
    localparam logic [FIELD_W-1:0] DATA_7    = 2'd2;
    localparam logic [FIELD_W-1:0] DATA_8    = 2'd3;
    localparam logic [FIELD_W-1:0] STOP_1    = 2'd0;
    localparam logic [FIELD_W-1:0] STOP_1P5  = 2'd1;
    localparam logic [FIELD_W-1:0] STOP_2    = 2'd2;
    localparam logic [FIELD_W-1:0] CHK_EVEN  = 2'd0;
    localparam logic [FIELD_W-1:0] CHK_ODD   = 2'd1;
    localparam logic [FIELD_W-1:0] CHK_MARK  = 2'd2;
    localparam logic [FIELD_W-1:0] CHK_SPACE = 2'd3;

    typedef struct packed {
        logic [DIV_W-1:0]   clk_div;
        logic               check_en;
        logic [FIELD_W-1:0] check_type;
        logic [FIELD_W-1:0] data_bit;
        logic [FIELD_W-1:0] stop_bit;
    } line_cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the pointer.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = SEL_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX engine among NUM_REQ requesters, one frame per grant,
// with per-requester line config latched into shadow registers at grant.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DIV_W-1:0]   cfg_clk_div,
    input  logic [NUM_REQ-1:0]         cfg_check_en,
    input  logic [NUM_REQ*FIELD_W-1:0] cfg_check_type,
    input  logic [NUM_REQ*FIELD_W-1:0] cfg_data_bit,
    input  logic [NUM_REQ*FIELD_W-1:0] cfg_stop_bit,
    output logic [DIV_W-1:0]           eng_clk_div,
    output logic                       eng_check_en,
    output logic [FIELD_W-1:0]         eng_check_type,
    output logic [FIELD_W-1:0]         eng_data_bit,
    output logic [FIELD_W-1:0]         eng_stop_bit,
    output logic [BYTE_W-1:0]          eng_data,
    output logic                       eng_valid,
    input  logic                       eng_ready,
    input  logic                       eng_busy,
    output logic [ID_W-1:0]            grant_id,
    output logic                       frame_active,
    output logic [STAT_W-1:0]          frame_count,
    output logic [STAT_W-1:0]          abort_count
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    sched_state_e      state;
    line_cfg_t         shadow;
    logic [SEL_W-1:0]  last_grant;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  hold_cnt;
    logic [1:0]        drain_cnt;

    line_cfg_t         cfg_arr  [NUM_REQ];
    logic [BYTE_W-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] arb_oh;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_any;
    logic [SEL_W-1:0]  g;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*BYTE_W +: BYTE_W];
            assign cfg_arr[gi]  = {cfg_clk_div[gi*DIV_W +: DIV_W],
                                   cfg_check_en[gi],
                                   cfg_check_type[gi*FIELD_W +: FIELD_W],
                                   cfg_data_bit[gi*FIELD_W +: FIELD_W],
                                   cfg_stop_bit[gi*FIELD_W +: FIELD_W]};
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (last_grant),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    assign arb_any = |arb_oh;
    assign g       = grant_id[SEL_W-1:0];
    assign accept  = (state == ST_SEND) && req_valid[g] && eng_ready;

    // Zero-latency pass-through of the owner's stream while sending.
    always_comb begin
        eng_valid = 1'b0;
        eng_data  = '0;
        req_ready = '0;
        if (state == ST_SEND) begin
            eng_valid    = req_valid[g];
            eng_data     = data_arr[g];
            req_ready[g] = eng_ready;
        end
    end

    assign frame_active   = (state != ST_IDLE);
    assign eng_clk_div    = shadow.clk_div;
    assign eng_check_en   = shadow.check_en;
    assign eng_check_type = shadow.check_type;
    assign eng_data_bit   = shadow.data_bit;
    assign eng_stop_bit   = shadow.stop_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            grant_id    <= '0;
            last_grant  <= SEL_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
            hold_cnt    <= '0;
            drain_cnt   <= '0;
            frame_count <= '0;
            abort_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_id  <= ID_W'(arb_idx);
                        shadow    <= cfg_arr[arb_idx];
                        burst_cnt <= '0;
                        hold_cnt  <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        hold_cnt  <= '0;
                        burst_cnt <= burst_cnt + CNT_W'(1);
                        if (req_last[g]) begin
                            frame_count <= frame_count + STAT_W'(1);
                            drain_cnt   <= '0;
                            state       <= ST_DRAIN;
                        end else if (MAX_BURST != 0 &&
                                     burst_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end
                    end else if (req_valid[g]) begin
                        hold_cnt <= '0;
                    end else if (HOLD_TIMEOUT != 0 &&
                                 hold_cnt + CNT_W'(1) == CNT_W'(HOLD_TIMEOUT)) begin
                        abort_count <= abort_count + STAT_W'(1);
                        drain_cnt   <= '0;
                        state       <= ST_DRAIN;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Wait out the engine's busy-rise latency before trusting eng_busy.
                    if (drain_cnt == 2'd2) begin
                        if (eng_ready && !eng_busy) begin
                            last_grant <= g;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench for uart_tx_scheduler with a frame-level
// round-robin reference model and a simple busy/ready engine model.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int HT = 20;

    logic          clk, rst_n;
    logic [3:0]    req_valid, req_last, req_ready;
    logic [31:0]   req_data;
    logic [127:0]  cfg_clk_div;
    logic [3:0]    cfg_check_en;
    logic [7:0]    cfg_check_type, cfg_data_bit, cfg_stop_bit;
    logic [31:0]   eng_clk_div;
    logic          eng_check_en;
    logic [1:0]    eng_check_type, eng_data_bit, eng_stop_bit;
    logic [7:0]    eng_data;
    logic          eng_valid, eng_ready, eng_busy;
    logic [2:0]    grant_id;
    logic          frame_active;
    logic [15:0]   frame_count, abort_count;

    uart_tx_scheduler #(.NUM_REQ(NR), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .cfg_clk_div(cfg_clk_div), .cfg_check_en(cfg_check_en), .cfg_check_type(cfg_check_type),
        .cfg_data_bit(cfg_data_bit), .cfg_stop_bit(cfg_stop_bit),
        .eng_clk_div(eng_clk_div), .eng_check_en(eng_check_en), .eng_check_type(eng_check_type),
        .eng_data_bit(eng_data_bit), .eng_stop_bit(eng_stop_bit),
        .eng_data(eng_data), .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_busy(eng_busy),
        .grant_id(grant_id), .frame_active(frame_active),
        .frame_count(frame_count), .abort_count(abort_count)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [7:0]  data;
        logic [31:0] div;
        logic        en;
        logic [1:0]  ty;
        logic [1:0]  db;
        logic [1:0]  sb;
    } beat_t;

    logic [7:0]  d_arr [4];
    logic [31:0] c_div [4];
    logic        c_en  [4];
    logic [1:0]  c_ty  [4];
    logic [1:0]  c_db  [4];
    logic [1:0]  c_sb  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pack
            assign req_data[gi*8 +: 8]         = d_arr[gi];
            assign cfg_clk_div[gi*32 +: 32]    = c_div[gi];
            assign cfg_check_en[gi]            = c_en[gi];
            assign cfg_check_type[gi*2 +: 2]   = c_ty[gi];
            assign cfg_data_bit[gi*2 +: 2]     = c_db[gi];
            assign cfg_stop_bit[gi*2 +: 2]     = c_sb[gi];
        end
    endgenerate

    logic [8:0] src_q [4][$];
    beat_t      exp_q [$];
    logic [2:0] gid_q [$];

    int   total = 0;
    int   bad   = 0;
    int   m_last, m_frames, m_aborts;
    int   busy_cnt;
    logic [3:0] acc;
    logic eng_acc;
    logic in_reset;
    logic gap_en, churn;
    logic mon_pa, mon_pb;
    logic [31:0] mon_pd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++)
            if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Round-robin from the model's last owner; plan the bytes this grant carries.
    task automatic plan_grant();
        int w;
        int n;
        bit last_seen;
        beat_t b;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (w < 0 && req_valid[c]) w = c;
        end
        if (w < 0) return;
        m_last = w;
        gid_q.push_back(3'(w));
        n = 0;
        last_seen = 1'b0;
        while (n < src_q[w].size() && n < MB && !last_seen) begin
            b.id   = 2'(w);
            b.data = src_q[w][n][7:0];
            b.div  = c_div[w];
            b.en   = c_en[w];
            b.ty   = c_ty[w];
            b.db   = c_db[w];
            b.sb   = c_sb[w];
            exp_q.push_back(b);
            last_seen = src_q[w][n][8];
            n++;
        end
        if (last_seen) m_frames++;
        else if (n < MB) m_aborts++;
    endtask

    task automatic step();
        logic [3:0] nv, nl;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (acc[i]) void'(src_q[i].pop_front());
        if (eng_acc) busy_cnt = 2 + int'($urandom_range(0, 3));
        else if (busy_cnt > 0) busy_cnt--;
        eng_busy  = (busy_cnt != 0);
        eng_ready = !eng_busy;
        if (churn && $urandom_range(0, 15) == 0) begin
            int r;
            r = int'($urandom_range(0, 3));
            c_div[r] = $urandom_range(1, 64);
            c_en[r]  = 1'($urandom_range(0, 1));
            c_ty[r]  = 2'($urandom_range(0, 3));
            c_db[r]  = 2'($urandom_range(0, 3));
            c_sb[r]  = 2'($urandom_range(0, 2));
        end
        nv = '0;
        nl = '0;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 7) != 0)) begin
                nv[i]    = 1'b1;
                d_arr[i] = src_q[i][0][7:0];
                nl[i]    = src_q[i][0][8];
            end
        end
        req_valid = nv;
        req_last  = nl;
        #1;
        acc     = req_valid & req_ready;
        eng_acc = eng_valid & eng_ready;
        if (!frame_active && req_valid != 4'd0) plan_grant();
    endtask

    task automatic quiet(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(all_empty() && exp_q.size() == 0 && !frame_active && busy_cnt == 0) && n < 4000);
        if (n >= 4000) fail_now({name, "_timeout"});
    endtask

    task automatic wait_active(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_active && n < 200);
        if (!frame_active) fail_now({name, "_no_grant"});
    endtask

    task automatic push_frame(input int r, input int len);
        for (int k = 0; k < len; k++)
            src_q[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
    endtask

    // Monitor: checks grants and every engine handshake against the scoreboard.
    initial begin
        beat_t b;
        mon_pa = 1'b0;
        mon_pb = 1'b0;
        mon_pd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!in_reset) begin
                if (frame_active && !mon_pa) begin
                    if (gid_q.size() == 0) fail_now("unexpected_grant");
                    else chk("grant_id", 32'(grant_id), 32'(gid_q.pop_front()));
                end
                if (eng_valid && eng_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_byte");
                    else begin
                        b = exp_q.pop_front();
                        chk("byte_owner", 32'(grant_id), 32'(b.id));
                        chk("eng_data", 32'(eng_data), 32'(b.data));
                        chk("eng_clk_div", eng_clk_div, b.div);
                        chk("eng_check_en", 32'(eng_check_en), 32'(b.en));
                        chk("eng_check_type", 32'(eng_check_type), 32'(b.ty));
                        chk("eng_data_bit", 32'(eng_data_bit), 32'(b.db));
                        chk("eng_stop_bit", 32'(eng_stop_bit), 32'(b.sb));
                    end
                end
                if (mon_pb) chk("cfg_stable_while_busy", eng_clk_div, mon_pd);
            end
            mon_pa = frame_active;
            mon_pb = eng_busy;
            mon_pd = eng_clk_div;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        gid_q.delete();
        acc       = '0;
        eng_acc   = 1'b0;
        busy_cnt  = 0;
        eng_busy  = 1'b0;
        eng_ready = 1'b1;
        req_valid = '0;
        req_last  = '0;
        m_last    = NR - 1;
        m_frames  = 0;
        m_aborts  = 0;
    endtask

    initial begin
        in_reset = 1'b1;
        rst_n    = 1'b0;
        gap_en   = 1'b0;
        churn    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_arr[i] = '0; c_div[i] = '0; c_en[i] = 1'b0;
            c_ty[i] = '0; c_db[i] = '0; c_sb[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_eng_valid", 32'(eng_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_eng_data", 32'(eng_data), 32'd0);
        chk("rst_eng_clk_div", eng_clk_div, 32'd0);
        chk("rst_frame_active", 32'(frame_active), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_abort_count", 32'(abort_count), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Requesters 0 and 2 together after reset: 0 first, then 2 with div 16.
        c_div[0] = 32'd8;  c_db[0] = DATA_8;
        c_div[2] = 32'd16; c_db[2] = DATA_7; c_sb[2] = STOP_2;
        push_frame(0, 3);
        push_frame(2, 2);
        quiet("two_req");
        chk("two_req_frames", 32'(frame_count), 32'(m_frames));
        chk("two_req_last_div", eng_clk_div, 32'd16);

        // Requester 1: 0x55, 0xA3, 0x0F with odd parity, div 8.
        c_div[1] = 32'd8; c_en[1] = 1'b1; c_ty[1] = CHK_ODD; c_db[1] = DATA_8; c_sb[1] = STOP_1;
        src_q[1].push_back({1'b0, 8'h55});
        src_q[1].push_back({1'b0, 8'hA3});
        src_q[1].push_back({1'b1, 8'h0F});
        quiet("single");
        chk("single_frames", 32'(frame_count), 32'd3);
        chk("single_grant_id", 32'(grant_id), 32'd1);

        // Burst limit: requester 3 streams 10 bytes while requester 1 queues short frames.
        gap_en = 1'b1;
        push_frame(3, 10);
        for (int k = 0; k < 3; k++) push_frame(1, 1);
        quiet("burst");
        chk("burst_frames", 32'(frame_count), 32'(m_frames));

        // Mid-frame config change only takes effect at the next grant.
        c_div[0] = 32'd8;
        push_frame(0, 3);
        wait_active("cfg_change");
        c_div[0] = 32'd4;
        push_frame(0, 2);
        quiet("cfg_change");
        chk("cfg_change_div", eng_clk_div, 32'd4);
        chk("cfg_change_frames", 32'(frame_count), 32'(m_frames));

        // Hold timeout: one byte without last, then valid drops.
        src_q[2].push_back({1'b0, 8'hC3});
        push_frame(0, 2);
        quiet("timeout");
        chk("timeout_aborts", 32'(abort_count), 32'd1);
        chk("timeout_frames", 32'(frame_count), 32'(m_frames));

        // Random mix with config churn.
        churn = 1'b1;
        for (int f = 0; f < 30; f++)
            push_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
        quiet("random");
        churn = 1'b0;
        chk("random_frames", 32'(frame_count), 32'(m_frames));
        chk("random_aborts", 32'(abort_count), 32'(m_aborts));

        // Reset during SEND.
        gap_en = 1'b0;
        push_frame(1, 3);
        wait_active("reset_mid");
        #2;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        #1;
        chk("rst_mid_eng_valid", 32'(eng_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_frame_active", 32'(frame_active), 32'd0);
        chk("rst_mid_frame_count", 32'(frame_count), 32'd0);
        chk("rst_mid_grant_id", 32'(grant_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        push_frame(2, 2);
        push_frame(0, 2);
        quiet("after_reset");
        chk("after_reset_frames", 32'(frame_count), 32'd2);
        chk("after_reset_last_owner", 32'(grant_id), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmit engine among `NUM_REQ` byte-stream requesters, each with its own line configuration (baud divisor, parity, data/stop bits). It grants the engine for a whole frame (up to `req_last`, or `MAX_BURST` bytes). It latches the winner's configuration into shadow registers and presents them to the engine only while the engine is idle, so line settings never change mid-character. It sits between the register-mapped channel FIFOs and the TX engine.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: bytes per grant before forced re-arbitration; 0 = unlimited.
- `HOLD_TIMEOUT`, 1024: cycles of `req_valid` low while granted before the frame is abandoned; 0 = never.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*8: byte of requester i at [8i+7:8i].
- `req_last` in NUM_REQ: byte is the last of its frame.
- `req_ready` out NUM_REQ: byte accepted when `req_valid[i] & req_ready[i]`.
- `cfg_clk_div` in NUM_REQ*32: per-requester divisor.
- `cfg_check_en` in NUM_REQ: per-requester parity enable.
- `cfg_check_type`, `cfg_data_bit`, `cfg_stop_bit` in NUM_REQ*2 each: per-requester settings, same encodings as the engine.
- `eng_clk_div` out 32; `eng_check_en` out 1; `eng_check_type`, `eng_data_bit`, `eng_stop_bit` out 2 each: shadow config driven to the engine.
- `eng_data` out 8; `eng_valid` out 1: byte to the engine.
- `eng_ready` in 1; `eng_busy` in 1: engine handshake and status.
- `grant_id` out 3: current or last owner.
- `frame_active` out 1: high in SEND and DRAIN.
- `frame_count` out 16: frames completed, wraps at 0xFFFF→0.
- `abort_count` out 16: frames abandoned by timeout, wraps.

## Operation
- States: IDLE, SEND, DRAIN.
- IDLE:
  - `eng_valid`=0, `req_ready`=0.
  - On the first cycle any `req_valid` is high, the round-robin winner is chosen: search starts at `(last_grant+1) mod NUM_REQ`.
  - Registered on that edge: `grant_id`, all shadow `eng_*` config from the winner's `cfg_*`, burst counter=0, hold counter=0. Next state SEND.
- SEND (pass-through, combinational):
  - `eng_valid = req_valid[g]`; `eng_data = req_data[g]`; `req_ready[g] = eng_ready`; all other `req_ready` are 0.
  - On each accepted byte, burst counter +1.
  - Go to DRAIN if the accepted byte has `req_last`=1 (`frame_count` +1), or the burst counter reaches `MAX_BURST` (frame continues at the next grant; no count change).
  - Hold counter: +1 each cycle `req_valid[g]`=0, cleared on any valid. On reaching `HOLD_TIMEOUT`, go to DRAIN and increment `abort_count`.
- DRAIN:
  - `eng_valid`=0; shadow config held.
  - Exits to IDLE on the first cycle with `eng_ready`=1 and `eng_busy`=0, evaluated no earlier than 2 cycles after entry (covers the engine's busy-rise latency).
  - `last_grant` is updated to `grant_id` on DRAIN exit.
- Shadow config changes only on the IDLE→SEND edge.
- `cfg_*` inputs are ignored at all other times; changing them mid-frame has no effect until the next grant.
- `grant_id` holds its value in IDLE.

## Timing
- Reset values:
  - State IDLE; `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `grant_id`=0, `eng_valid`=0, `req_ready`=0, `eng_data`=0.
  - All `eng_*` config=0; `frame_active`=0; counters=0.
- Grant latency: `req_valid` seen in IDLE at cycle T → SEND at T+1 → `eng_valid` possible at T+1, with shadow config already stable.
- Within a frame, bytes pass with zero added latency; engine back-pressure alone paces them.
- Frame-to-frame gap: at least 1 IDLE cycle after the engine goes idle.
- Simultaneous requests: round-robin only; no requester wins twice while another is waiting.
- Burst limit and `req_last` on the same byte: treated as `req_last` (`frame_count` +1).
- Timeout and acceptance in the same cycle: acceptance wins, and the hold counter clears.
- Reset mid-frame: immediate return to reset values. The engine is reset by the same `rst_n`.

## Structure
- Shared package `uart_pkg`: state encodings; config field widths; data_bit/stop_bit/check_type encodings (common with the engine).
- One sub-module, `rr_arbiter`: parameterised round-robin pick (`NUM_REQ`-bit request and pointer in, one-hot and index out), combinational.

## Test plan
- Single requester 1, 3-byte frame 0x55,0xA3,0x0F with last on the third byte, clk_div=8, odd parity → engine receives exactly those bytes with the req 1 config; `frame_count`=1; `grant_id`=1.
- Requesters 0 and 2 both valid in the same cycle after reset → 0 granted first. After its last byte drains, 2 is granted, and `eng_clk_div` switches from 8 to 16 only after `eng_busy` falls.
- `MAX_BURST`=4, requester 3 streams 10 bytes while requester 1 waits → grant sequence 3(4 bytes), 1, 3(4), 1…; `frame_count` increments only on last bytes.
- `cfg_clk_div[0]` changed from 8 to 4 mid-frame → `eng_clk_div` stays 8 until the next grant.
- `HOLD_TIMEOUT`=20, requester 2 sends 1 byte and drops valid → DRAIN after 20 cycles, `abort_count`=1, and the next requester is granted.
- `rst_n` asserted during SEND → `eng_valid`, `req_ready`, and `frame_active` are 0 immediately; after release, requester 0 has priority.
